// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths,
// operation encodings, FSM states and a small magnitude helper.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = XLEN;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Two's-complement magnitude when neg is set; raw value otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO.
// Radix-2, one bit per cycle over operand magnitudes, followed by a single
// sign-fixup cycle. busy covers the whole RUN+FIX window; done pulses on
// the edge that writes HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // opnd holds the multiplicand (mult) or divisor (div) magnitude.
    logic [XLEN-1:0]   opnd_q, opnd_d;
    // acc is {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              is_md_op;
    logic              signed_op;
    logic              op_is_div;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_quo;
    logic [XLEN-1:0]   fix_rem;

    assign is_md_op  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign a_mag     = mag(rs_data, signed_op & rs_data[XLEN-1]);
    assign b_mag     = mag(rt_data, signed_op & rt_data[XLEN-1]);

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide step: shift {rem, dividend} left by one and trial-subtract.
    assign div_trial = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_trial - {1'b0, opnd_q};

    assign fix_prod  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign fix_quo   = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign fix_rem   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    // Next-state, datapath and HI/LO update; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_md_op) begin
                        is_div_d  = op_is_div;
                        neg_res_d = signed_op & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                        neg_rem_d = signed_op & rs_data[XLEN-1];
                        opnd_d    = op_is_div ? b_mag : a_mag;
                        acc_d     = {{XLEN{1'b0}}, (op_is_div ? a_mag : b_mag)};
                        cnt_d     = '0;
                        state_d   = RUN;
                    end else if (op == MD_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == MD_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (div_diff[XLEN]) begin
                        acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    // A zero divisor leaves the dividend as remainder; only
                    // the quotient needs forcing to all ones.
                    lo_d = (opnd_q == '0) ? '1 : fix_quo;
                    hi_d = fix_rem;
                end else begin
                    {hi_d, lo_d} = fix_prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table of directed vectors, model-checked random
// vectors, and hand sequences for MT*, ignored start, flush and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    muldiv_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] exp_hi;
        logic [XLEN-1:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    logic [2*XLEN-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic [XLEN-1:0] m_hi = '0;
    logic [XLEN-1:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference results from plain SV arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            MD_MULT:  begin p = sa * sb; return p; end
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Issue one mult/div, follow busy to completion, score HI/LO on done.
    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] e);
        int cyc;
        bit early_done;
        logic [63:0] got;
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom_range(0, 7));
        cyc = 0;
        early_done = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) early_done = 1;
            rs_data = $urandom;
            rt_data = $urandom;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(cyc), 64'd33);
        check({name, " done_during_busy"}, {63'b0, early_done}, 64'd0);
        check({name, " done_pulse"}, {63'b0, done}, 64'd1);
        got = exp_q.pop_front();
        check({name, " hi"}, {32'b0, hi}, {32'b0, got[63:32]});
        check({name, " lo"}, {32'b0, lo}, {32'b0, got[31:0]});
        m_hi = got[63:32];
        m_lo = got[31:0];
        @(negedge clk);
        check({name, " done_width"}, {63'b0, done}, 64'd0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[6] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        // Reset
        rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", {32'b0, hi}, 64'd0);
        check("reset lo", {32'b0, lo}, 64'd0);
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTLO / MTHI / reserved op while idle
        start = 1'b1; op = MD_MTLO; rs_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        check("mtlo lo", {32'b0, lo}, 64'h00000000A5A5A5A5);
        check("mtlo hi", {32'b0, hi}, 64'd0);
        check("mtlo busy", {63'b0, busy}, 64'd0);
        check("mtlo done", {63'b0, done}, 64'd0);
        @(negedge clk);
        op = MD_MTHI; rs_data = 32'h5A5A1234;
        @(posedge clk); #1;
        check("mthi hi", {32'b0, hi}, 64'h000000005A5A1234);
        check("mthi lo", {32'b0, lo}, 64'h00000000A5A5A5A5);
        @(negedge clk);
        op = 3'd7; rs_data = 32'h0BADF00D;
        @(posedge clk); #1;
        check("reserved hi", {32'b0, hi}, 64'h000000005A5A1234);
        check("reserved lo", {32'b0, lo}, 64'h00000000A5A5A5A5);
        check("reserved busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        m_hi = 32'h5A5A1234;
        m_lo = 32'hA5A5A5A5;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i == 5) rb = -32'sd3;
            run_md($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
        end

        // Start while busy is ignored; flush cancels without writing HI/LO
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MD_MTHI; rs_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        check("ignored mthi hi", {32'b0, hi}, {32'b0, m_hi});
        check("ignored mthi busy", {63'b0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush busy", {63'b0, busy}, 64'd0);
        check("flush done", {63'b0, done}, 64'd0);
        check("flush hi", {32'b0, hi}, {32'b0, m_hi});
        check("flush lo", {32'b0, lo}, {32'b0, m_lo});
        @(negedge clk);
        flush = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("flush no late done", {63'b0, saw_done}, 64'd0);
        check("flush hi kept", {32'b0, hi}, {32'b0, m_hi});

        // Reset mid-operation clears immediately
        run_md("post_flush", MD_MULTU, 32'h00012345, 32'h00000100, 64'h0000000001234500);
        @(negedge clk);
        start = 1'b1; op = MD_MULT; rs_data = 32'd3; rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", {63'b0, busy}, 64'd0);
        check("midrst done", {63'b0, done}, 64'd0);
        check("midrst hi", {32'b0, hi}, 64'd0);
        check("midrst lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("midrst no done", {63'b0, saw_done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
